// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared direction and mode encodings for the counter library.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_next_state.sv
// ============================================================================
// Module : counter_next_state
// Brief  : Combinational next-count, terminal-count and saturate-tracking logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_mod_max,
    input  logic             i_up_dn,
    input  logic             i_sat_mode,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_sat_hit,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_tc_next,
    output logic             o_sat_hit_next
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic w_sat;
    logic w_up;

    assign w_sat = (i_sat_mode == MODE_SAT);
    assign w_up  = (i_up_dn == DIR_UP);

    always_comb begin
        o_q_next       = i_q;
        o_tc_next      = 1'b0;
        o_sat_hit_next = i_sat_hit;

        if (i_load) begin
            o_q_next       = (i_load_val > i_mod_max) ? i_mod_max : i_load_val;
            o_sat_hit_next = 1'b0;
        end else if (i_en) begin
            if (i_q > i_mod_max) begin
                // Modulus was lowered under us: snap back into range and flag it
                o_q_next       = (w_up && !w_sat) ? c_zero : i_mod_max;
                o_tc_next      = 1'b1;
                o_sat_hit_next = w_up && w_sat;
            end else if (w_up) begin
                if (i_q == i_mod_max) begin
                    if (w_sat) begin
                        o_tc_next      = !i_sat_hit;
                        o_sat_hit_next = 1'b1;
                    end else begin
                        o_q_next       = c_zero;
                        o_tc_next      = 1'b1;
                        o_sat_hit_next = 1'b0;
                    end
                end else begin
                    o_q_next       = i_q + c_one;
                    o_tc_next      = w_sat && (i_q + c_one == i_mod_max);
                    o_sat_hit_next = w_sat && (i_q + c_one == i_mod_max);
                end
            end else begin
                if (i_q == c_zero) begin
                    if (w_sat) begin
                        o_tc_next      = !i_sat_hit;
                        o_sat_hit_next = 1'b1;
                    end else begin
                        o_q_next       = i_mod_max;
                        o_tc_next      = 1'b1;
                        o_sat_hit_next = 1'b0;
                    end
                end else begin
                    o_q_next       = i_q - c_one;
                    o_tc_next      = w_sat && (i_q == c_one);
                    o_sat_hit_next = w_sat && (i_q == c_one);
                end
            end
        end
    end

endmodule : counter_next_state

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ============================================================================
// Module : updown_mod_counter
// Brief  : Up/down modulo counter with load, wrap/saturate and registered tc.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             at_zero,
    output logic             at_max
);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_sat_hit;

    logic [WIDTH-1:0] w_q_next;
    logic             w_tc_next;
    logic             w_sat_hit_next;

    counter_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_q            (r_q),
        .i_mod_max      (mod_max),
        .i_up_dn        (up_dn),
        .i_sat_mode     (sat_mode),
        .i_load         (load),
        .i_load_val     (load_val),
        .i_en           (en),
        .i_sat_hit      (r_sat_hit),
        .o_q_next       (w_q_next),
        .o_tc_next      (w_tc_next),
        .o_sat_hit_next (w_sat_hit_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= RST_VAL;
            r_tc      <= 1'b0;
            r_sat_hit <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_tc      <= w_tc_next;
            r_sat_hit <= w_sat_hit_next;
        end
    end

    assign q       = r_q;
    assign tc      = r_tc;
    assign at_zero = (r_q == '0);
    assign at_max  = (r_q == mod_max);

endmodule : updown_mod_counter

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
// ============================================================================
// Module : tb_updown_mod_counter
// Brief  : Scoreboard bench for updown_mod_counter at WIDTH 4 and WIDTH 8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_updown_mod_counter;

    typedef struct {
        int          dut;
        logic [31:0] q;
        logic        tc;
        logic [31:0] mm;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    bit   clk_run = 1'b1;
    logic rst_n = 1'b1;

    logic       a_en = 0, a_up = 0, a_load = 0, a_sat = 0;
    logic [3:0] a_lv = '0, a_mm = 4'd15;
    logic [3:0] a_q;
    logic       a_tc, a_az, a_am;

    logic       b_en = 0, b_up = 0, b_load = 0, b_sat = 0;
    logic [7:0] b_lv = '0, b_mm = 8'd200;
    logic [7:0] b_q;
    logic       b_tc, b_az, b_am;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 if (clk_run) clk = ~clk;

    updown_mod_counter #(.WIDTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .mod_max(a_mm), .sat_mode(a_sat),
        .q(a_q), .tc(a_tc), .at_zero(a_az), .at_max(a_am)
    );

    updown_mod_counter #(.WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lv), .mod_max(b_mm), .sat_mode(b_sat),
        .q(b_q), .tc(b_tc), .at_zero(b_az), .at_max(b_am)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one edge worth of stimulus on the selected counter and queue its expected result
    task automatic step(input int d, input bit ld, input int lv, input bit e, input bit ud,
                        input bit sm, input int mm, input int eq, input bit etc, input string nm);
        exp_t x;
        @(negedge clk);
        a_en = 0; a_load = 0; b_en = 0; b_load = 0;
        if (d == 0) begin
            a_load = ld; a_lv = 4'(lv); a_en = e; a_up = ud; a_sat = sm; a_mm = 4'(mm);
        end else begin
            b_load = ld; b_lv = 8'(lv); b_en = e; b_up = ud; b_sat = sm; b_mm = 8'(mm);
        end
        x.dut = d; x.q = eq; x.tc = etc; x.mm = mm; x.name = nm;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t        x;
        logic [31:0] aq;
        logic        atc, az, am;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.dut == 0) begin
                    aq = 32'(a_q); atc = a_tc; az = a_az; am = a_am;
                end else begin
                    aq = 32'(b_q); atc = b_tc; az = b_az; am = b_am;
                end
                chk({x.name, " q"},       aq,         x.q);
                chk({x.name, " tc"},      32'(atc),   32'(x.tc));
                chk({x.name, " at_zero"}, 32'(az),    32'(x.q == 0));
                chk({x.name, " at_max"},  32'(am),    32'(x.q == x.mm));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int budget;
        #2 rst_n = 0;
        #1;
        chk("por a q",  32'(a_q),  32'd15);
        chk("por a tc", 32'(a_tc), 32'd0);
        chk("por b q",  32'(b_q),  32'd255);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // step(dut, load, load_val, en, up, sat, mod_max, exp_q, exp_tc, name)
        step(0, 0, 0, 1, 0, 0, 15, 14, 0, "first down");
        step(0, 1, 0, 0, 0, 0,  9,  0, 0, "pre-abort load");
        step(0, 0, 0, 1, 0, 0,  9,  9, 1, "pre-abort wrap");

        // Reset with the clock parked low: must act without any edge
        @(negedge clk);
        a_en = 0; a_mm = 4'd15;
        clk_run = 0;
        #3 rst_n = 0;
        #2;
        chk("async rst q",  32'(a_q),  32'd15);
        chk("async rst tc", 32'(a_tc), 32'd0);
        #3 rst_n = 1;
        #9 clk_run = 1;
        step(0, 0, 0, 1, 0, 0, 15, 14, 0, "post-rst down");

        step(0, 1, 2, 0, 0, 0, 9, 2, 0, "dw load");
        step(0, 0, 0, 1, 0, 0, 9, 1, 0, "dw 1");
        step(0, 0, 0, 1, 0, 0, 9, 0, 0, "dw 0");
        step(0, 0, 0, 1, 0, 0, 9, 9, 1, "dw wrap");
        step(0, 0, 0, 1, 0, 0, 9, 8, 0, "dw 8");

        step(0, 1, 3, 0, 1, 1, 5, 3, 0, "us load");
        step(0, 0, 0, 1, 1, 1, 5, 4, 0, "us 4");
        step(0, 0, 0, 1, 1, 1, 5, 5, 1, "us reach");
        step(0, 0, 0, 1, 1, 1, 5, 5, 0, "us hold1");
        step(0, 0, 0, 1, 1, 1, 5, 5, 0, "us hold2");
        step(0, 0, 0, 1, 1, 1, 5, 5, 0, "us hold3");

        step(0, 1, 0, 0, 0, 1, 5, 0, 0, "ds load0");
        step(0, 0, 0, 1, 0, 1, 5, 0, 1, "ds first hold");
        step(0, 0, 0, 1, 0, 1, 5, 0, 0, "ds rehold");

        step(0, 1, 12, 1, 1, 0, 7, 7, 0, "prio load clamp");
        step(0, 0, 0,  0, 1, 0, 7, 7, 0, "prio hold");

        step(0, 1, 10, 0, 1, 0, 15, 10, 0, "shrink load up");
        step(0, 0, 0,  1, 1, 0, 6,   0, 1, "shrink up wrap");
        step(0, 1, 10, 0, 0, 0, 15, 10, 0, "shrink load dn");
        step(0, 0, 0,  1, 0, 0, 6,   6, 1, "shrink down");

        step(0, 1, 0, 0, 1, 0, 0, 0, 0, "deg load");
        step(0, 0, 0, 1, 1, 0, 0, 0, 1, "deg up 1");
        step(0, 0, 0, 1, 1, 0, 0, 0, 1, "deg up 2");
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, "deg dn 3");

        step(1, 1, 2, 0, 0, 0, 200,   2, 0, "w8 load");
        step(1, 0, 0, 1, 0, 0, 200,   1, 0, "w8 1");
        step(1, 0, 0, 1, 0, 0, 200,   0, 0, "w8 0");
        step(1, 0, 0, 1, 0, 0, 200, 200, 1, "w8 wrap");
        step(1, 0, 0, 1, 0, 0, 200, 199, 0, "w8 199");

        @(negedge clk);
        a_en = 0; a_load = 0; b_en = 0; b_load = 0;
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_updown_mod_counter

`default_nettype wire
